// File: rtl/instr_fetch_aligner_pkg.sv
// Shared widths and encodings for the instruction fetch aligner.
package instr_fetch_aligner_pkg;

  localparam int HW = 16;
  localparam int WORD = 32;
  localparam logic [1:0] RVC_FULL = 2'b11;

  function automatic logic is_full_len(input logic [HW-1:0] hw);
    return hw[1:0] == RVC_FULL;
  endfunction

endpackage

// File: rtl/instr_fetch_aligner_hw_queue.sv
// Halfword FIFO feeding the aligner: pushes 0/1/2 halfwords from a fetched word,
// pops 0/1/2 halfwords per accepted instruction, exposes the two head entries.
module instr_fetch_aligner_hw_queue
  import instr_fetch_aligner_pkg::*;
#(
  parameter int QDEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     wr_lo,
  input  logic                     wr_hi,
  input  logic [WORD-1:0]          wr_data,
  input  logic [1:0]               pop_cnt,
  output logic [HW-1:0]            head0,
  output logic [HW-1:0]            head1,
  output logic [$clog2(QDEPTH):0]  count
);

  localparam int PW = $clog2(QDEPTH);

  logic [HW-1:0] q [QDEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] hi_slot;
  logic [1:0]    push_cnt;

  // The high halfword lands behind the low one, or at the tail when the low one is dropped.
  always_comb begin
    push_cnt = {1'b0, wr_lo} + {1'b0, wr_hi};
    hi_slot  = wr_lo ? wr_ptr + PW'(1) : wr_ptr;
    head0    = q[rd_ptr];
    head1    = q[rd_ptr + PW'(1)];
  end

  always_ff @(posedge clk) begin
    if (wr_lo) q[wr_ptr] <= wr_data[HW-1:0];
    if (wr_hi) q[hi_slot] <= wr_data[WORD-1:HW];
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_cnt);
      rd_ptr <= rd_ptr + PW'(pop_cnt);
      count  <= count + (PW + 1)'(push_cnt) - (PW + 1)'(pop_cnt);
    end
  end

endmodule

// File: rtl/instr_fetch_aligner.sv
// Program memory plus fetch/align front end: streams words into a halfword queue and
// presents 16/32-bit instructions at any halfword PC to decode over valid/ready.
module instr_fetch_aligner
  import instr_fetch_aligner_pkg::*;
#(
  parameter int          MEM_WORDS = 1904,
  parameter logic [31:0] BASE_ADDR = 32'h80000000,
  parameter logic [31:0] RESET_PC  = 32'h8000006c,
  parameter int          QDEPTH    = 8,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        compressed_or_not,
  output logic        fetch_fault
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CW    = $clog2(QDEPTH) + 1;

  logic [WORD-1:0] mem [MEM_WORDS];

  logic [31:0]     fetch_addr;
  logic [31:0]     pc_q;
  logic [31:0]     offset;
  logic            drop_lo;
  logic            fault_pending;
  logic [HW-1:0]   head0;
  logic [HW-1:0]   head1;
  logic [CW-1:0]   count;
  logic            want_fetch;
  logic            in_range;
  logic            issue;
  logic            full_len;
  logic            can_form;
  logic            transfer;
  logic [1:0]      pop_cnt;
  logic [WORD-1:0] rd_word;
  logic            unused_bits;

  // Slot check uses the pre-pop count, so a pop only makes room for the next cycle.
  always_comb begin
    offset      = fetch_addr - BASE_ADDR;
    in_range    = (fetch_addr >= BASE_ADDR) && (offset[31:2] < 30'(MEM_WORDS));
    want_fetch  = !fault_pending && (count <= CW'(QDEPTH - 2));
    issue       = want_fetch && in_range && !redirect_valid;
    rd_word     = mem[offset[IDX_W+1:2]];
    full_len    = is_full_len(head0);
    can_form    = full_len ? (count >= CW'(2)) : (count >= CW'(1));
    instr_valid = can_form && !redirect_valid;
    transfer    = instr_valid && instr_ready;
    pop_cnt     = transfer ? (full_len ? 2'd2 : 2'd1) : 2'd0;
    if (!can_form)     instr = '0;
    else if (full_len) instr = {head1, head0};
    else               instr = {16'b0, head0};
    compressed_or_not = (count != '0) && !full_len;
    fetch_fault       = fault_pending && !can_form;
    instr_pc          = pc_q;
    unused_bits       = ^{offset[1:0], redirect_pc[0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_addr    <= {RESET_PC[31:2], 2'b00};
      drop_lo       <= RESET_PC[1];
      pc_q          <= RESET_PC;
      fault_pending <= 1'b0;
    end else if (redirect_valid) begin
      fetch_addr    <= {redirect_pc[31:2], 2'b00};
      drop_lo       <= redirect_pc[1];
      pc_q          <= {redirect_pc[31:1], 1'b0};
      fault_pending <= 1'b0;
    end else begin
      if (want_fetch && !in_range) fault_pending <= 1'b1;
      if (issue) begin
        fetch_addr <= fetch_addr + 32'd4;
        drop_lo    <= 1'b0;
      end
      if (transfer) pc_q <= pc_q + (full_len ? 32'd4 : 32'd2);
    end
  end

  instr_fetch_aligner_hw_queue #(
    .QDEPTH(QDEPTH)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .flush   (redirect_valid),
    .wr_lo   (issue && !drop_lo),
    .wr_hi   (issue),
    .wr_data (rd_word),
    .pop_cnt (pop_cnt),
    .head0   (head0),
    .head1   (head1),
    .count   (count)
  );

endmodule

// File: tb/tb_instr_fetch_aligner.sv
// Directed bench for instr_fetch_aligner: reset, RVC pairs, straddling words,
// stall/fill, redirect during transfer, misaligned redirect, fault and reset recovery.
module tb_instr_fetch_aligner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_ready = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        compressed_or_not;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  instr_fetch_aligner dut (
    .clk               (clk),
    .reset             (reset),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .instr_ready       (instr_ready),
    .instr_valid       (instr_valid),
    .instr             (instr),
    .instr_pc          (instr_pc),
    .compressed_or_not (compressed_or_not),
    .fetch_fault       (fetch_fault)
  );

  always #5 clk = ~clk;

  // Advance one edge, then drive the inputs for the cycle that just began.
  task automatic applyStimulus(input logic rst, input logic rv, input logic [31:0] rpc,
                               input logic rdy);
    @(posedge clk);
    #1;
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    instr_ready    = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkInstr(input string tag, input logic [31:0] exp_instr,
                            input logic [31:0] exp_pc, input logic exp_c);
    checkOutput({tag, ".valid"}, 32'(instr_valid), 32'd1);
    checkOutput({tag, ".instr"}, instr, exp_instr);
    checkOutput({tag, ".pc"}, instr_pc, exp_pc);
    checkOutput({tag, ".c"}, 32'(compressed_or_not), 32'(exp_c));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int i = 0; i < 1904; i++) dut.mem[i] = 32'h0;
    dut.mem[27]   = 32'h00000013;
    dut.mem[28]   = 32'h00000013;
    dut.mem[32]   = 32'h45014581;
    dut.mem[36]   = 32'h00134501;
    dut.mem[37]   = 32'h45010000;
    dut.mem[1903] = 32'h00130001;

    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("rst.valid", 32'(instr_valid), 32'd0);
    checkOutput("rst.instr", instr, 32'h0);
    checkOutput("rst.c", 32'(compressed_or_not), 32'd0);
    checkOutput("rst.fault", 32'(fetch_fault), 32'd0);
    checkOutput("rst.pc", instr_pc, 32'h8000006c);

    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("rel.c0.valid", 32'(instr_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkInstr("rel.c1", 32'h00000013, 32'h8000006c, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkInstr("rel.c2", 32'h00000013, 32'h80000070, 1'b0);

    applyStimulus(1'b0, 1'b1, 32'h80000080, 1'b0);
    checkOutput("rd80.c0.valid", 32'(instr_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("rd80.c1.valid", 32'(instr_valid), 32'd0);
    checkOutput("rd80.c1.pc", instr_pc, 32'h80000080);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkInstr("rd80.c2", 32'h00004581, 32'h80000080, 1'b1);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkInstr("stall", 32'h00004581, 32'h80000080, 1'b1);
    end
    checkOutput("stall.count", 32'(dut.u_queue.count), 32'd8);

    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkInstr("drain0", 32'h00004581, 32'h80000080, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkInstr("drain1", 32'h00004501, 32'h80000082, 1'b1);

    applyStimulus(1'b0, 1'b1, 32'h80000090, 1'b1);
    checkOutput("rdxfer.c0.valid", 32'(instr_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("rdxfer.c1.valid", 32'(instr_valid), 32'd0);
    checkOutput("rdxfer.c1.pc", instr_pc, 32'h80000090);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkInstr("strad0", 32'h00004501, 32'h80000090, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkInstr("strad1", 32'h00000013, 32'h80000092, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkInstr("strad2", 32'h00004501, 32'h80000096, 1'b1);

    applyStimulus(1'b0, 1'b1, 32'h80000093, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("odd.c1.pc", instr_pc, 32'h80000092);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("odd.c2.valid", 32'(instr_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkInstr("odd.c3", 32'h00000013, 32'h80000092, 1'b0);

    applyStimulus(1'b0, 1'b1, 32'h80001dbc, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkInstr("last.c2", 32'h00000001, 32'h80001dbc, 1'b1);
    checkOutput("last.c2.fault", 32'(fetch_fault), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("fault.valid", 32'(instr_valid), 32'd0);
    checkOutput("fault.flag", 32'(fetch_fault), 32'd1);
    checkOutput("fault.pc", instr_pc, 32'h80001dbe);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("fault.sticky", 32'(fetch_fault), 32'd1);
    checkOutput("fault.sticky.pc", instr_pc, 32'h80001dbe);

    applyStimulus(1'b0, 1'b1, 32'h80000080, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("clr.fault", 32'(fetch_fault), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkInstr("clr.c2", 32'h00004581, 32'h80000080, 1'b1);

    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("rst2.valid", 32'(instr_valid), 32'd0);
    checkOutput("rst2.pc", instr_pc, 32'h8000006c);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkInstr("rst2.c1", 32'h00000013, 32'h8000006c, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
